strip_ram_mp: RTL and testbench
===============================

# strip_ram_mp

Parametrised multi-read-port strip-state RAM for the multi-program placement datapath: one write port, NUM_RD registered read ports, DEPTH entries of DATA_WIDTH bits. Entry 0 is a read-only sentinel holding INIT0. A built-in clear engine initialises the array after reset or on request, replacing bulk reset of the storage. Read and write in the same cycle are both serviced, with optional write-to-read forwarding.

## Interface
- ADDR_WIDTH, 4, address bits; DEPTH must satisfy DEPTH <= 2**ADDR_WIDTH
- DATA_WIDTH, 8, entry width
- DEPTH, 14, number of entries
- NUM_RD, 3, number of read ports (>=1)
- INIT0, 128, value loaded into entry 0 by the clear engine
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- init_req  in  1  request a full clear; accepted only in IDLE
- busy  out  1  clear engine running; reads and writes rejected
- write_en  in  1  write strobe
- addr_write  in  ADDR_WIDTH  write address
- data_in  in  DATA_WIDTH  write data
- wr_err  out  1  one-cycle pulse: write dropped (busy, addr 0, or addr >= DEPTH)
- read_en  in  1  read strobe, applies to all ports
- addr_read  in  NUM_RD*ADDR_WIDTH  packed read addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- data_out  out  NUM_RD*DATA_WIDTH  packed registered read data, same packing
- rd_valid  out  1  one-cycle pulse: data_out updated by an accepted read

## Operation
- States: CLEAR, IDLE. Reset forces CLEAR with clr_cnt=0; busy=1, data_out=0, rd_valid=0, wr_err=0. Storage contents are not reset directly.
- CLEAR: each edge writes entry clr_cnt (INIT0 if clr_cnt==0, else 0) and increments clr_cnt. The edge writing entry DEPTH-1 moves to IDLE. busy = (state==CLEAR).
- IDLE: init_req=1 -> CLEAR with clr_cnt=0. Write and read requests in the same cycle are handled first, then the clear begins. init_req in CLEAR is ignored.
- Write is accepted when state==IDLE, write_en=1, and 0 < addr_write < DEPTH. Any other write_en=1 is dropped and pulses wr_err on the next cycle.
- Read is accepted when state==IDLE and read_en=1. Every port registers mem[addr] and rd_valid pulses.
  - A port with addr >= DEPTH returns 0.
  - Ports are independent; duplicate addresses are legal.
- read_en=0 or read rejected: data_out holds its value and rd_valid=0. A read attempted while busy is silently dropped (no error flag).
- Simultaneous accepted read and write to the same address: see Configuration.
- Reset mid-CLEAR or mid-operation restarts CLEAR from entry 0.

## Timing
- Read latency is 1 cycle. Request is sampled at edge N; data_out and rd_valid are valid after edge N. Back-to-back reads are possible every cycle.
- Write is visible to reads sampled at edge N+1 or later.
- After rst deasserts, the clear occupies exactly DEPTH edges. busy falls after edge DEPTH. The first accepted access is at edge DEPTH+1.
- init_req sampled at edge N: busy=1 after edge N, and busy=0 after edge N+DEPTH.
- wr_err and rd_valid are single-cycle registered pulses.

## Configuration
- WRITE_BYPASS_EN defined: a read port addressing the entry written in the same cycle returns data_in (forwarding).
- WRITE_BYPASS_EN undefined: that port returns the pre-write contents.
- Either way, the write still lands in the array.

## Structure
- Package strip_ram_pkg holds:
  - the state enum (CLEAR, IDLE);
  - default parameter constants (DEFAULT_DEPTH=14, DEFAULT_INIT0=128, DEFAULT_NUM_RD=3);
  - the sentinel address constant SENTINEL_ADDR=0.
- Sub-module strip_ram_rd_port: one read port containing the range check, the bypass mux under WRITE_BYPASS_EN, and the data_out register. It is instantiated NUM_RD times via generate.
- The top level holds the storage array, the clear FSM/counter, and write qualification.

## Test plan
- Clear sequence:
  - Release rst, count edges until busy falls -> exactly 14 edges.
  - Then read addresses 0,1,13 -> 128, 0, 0, with rd_valid pulsed once.
- Write/read:
  - Write 8'h5A to 3 and 8'hC3 to 12.
  - Next cycle, read ports = {3,12,3} -> {5A,C3,5A}, 1-cycle latency.
- Write protection:
  - Write 8'hFF to addr 0 -> wr_err pulse; read 0 -> 128.
  - Write to addr 14 and 15 -> wr_err pulse each; no entry changes.
- Simultaneous access:
  - Write 8'h77 to 5 while reading 5.
  - With WRITE_BYPASS_EN -> 77; without -> old value 0. In both cases the next read returns 77.
- Busy rejection:
  - Pulse init_req, then write addr 4 and read during busy -> wr_err, no rd_valid, data_out held.
  - After 14 edges, entry 4 reads 0.
- Reset mid-clear:
  - Assert rst at clear edge 6 -> outputs 0 immediately.
  - After release, a full 14-edge clear completes and entry 0 = 128.

Source files
------------

// File: rtl/strip_ram_pkg.sv
// rtl/strip_ram_pkg.sv - shared state encoding and default constants for the strip-state RAM
package strip_ram_pkg;

    localparam int DEFAULT_DEPTH  = 14;
    localparam int DEFAULT_INIT0  = 128;
    localparam int DEFAULT_NUM_RD = 3;
    localparam int SENTINEL_ADDR  = 0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

endpackage

// File: rtl/strip_ram_rd_port.sv
// rtl/strip_ram_rd_port.sv - one registered read port with range check; forwarding under WRITE_BYPASS_EN
module strip_ram_rd_port #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 14
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_accept,
    input  logic [ADDR_WIDTH-1:0]       addr,
    input  logic [DEPTH*DATA_WIDTH-1:0] mem_flat,
    input  logic                        wr_accept,
    input  logic [ADDR_WIDTH-1:0]       addr_write,
    input  logic [DATA_WIDTH-1:0]       data_in,
    output logic [DATA_WIDTH-1:0]       data_out
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] word;

    always_comb begin
        word = '0;
        if ({1'b0, addr} < DEPTH_W) begin
            word = mem_flat[int'(addr)*DATA_WIDTH +: DATA_WIDTH];
        end
`ifdef WRITE_BYPASS_EN
        if (wr_accept && (addr_write == addr)) begin
            word = data_in;
        end
`endif
    end

`ifndef WRITE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{wr_accept, addr_write, data_in};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
        end else if (rd_accept) begin
            data_out <= word;
        end
    end

endmodule

// File: rtl/strip_ram_mp.sv
// rtl/strip_ram_mp.sv - multi-read-port strip-state RAM with clear engine; optional WRITE_BYPASS_EN forwarding
module strip_ram_mp
    import strip_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int NUM_RD     = DEFAULT_NUM_RD,
    parameter int INIT0      = DEFAULT_INIT0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         init_req,
    output logic                         busy,
    input  logic                         write_en,
    input  logic [ADDR_WIDTH-1:0]        addr_write,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic                         wr_err,
    input  logic                         read_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] addr_read,
    output logic [NUM_RD*DATA_WIDTH-1:0] data_out,
    output logic                         rd_valid
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(DEPTH-1);
    localparam logic [ADDR_WIDTH-1:0] SENTINEL = ADDR_WIDTH'(SENTINEL_ADDR);

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH*DATA_WIDTH-1:0] mem_flat;
    logic                    clr_last, wr_accept, rd_accept;

    assign busy      = (state == ST_CLEAR);
    assign clr_last  = (clr_cnt == LAST);
    assign wr_accept = (state == ST_IDLE) && write_en && (addr_write != SENTINEL)
                       && ({1'b0, addr_write} < DEPTH_W);
    assign rd_accept = (state == ST_IDLE) && read_en;

    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR: if (clr_last) state_next = ST_IDLE;
            ST_IDLE:  if (init_req) state_next = ST_CLEAR;
            default:  state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_CLEAR;
            clr_cnt  <= '0;
            wr_err   <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            state    <= state_next;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
            end
            wr_err   <= write_en && !wr_accept;
            rd_valid <= rd_accept;
        end
    end

    // Storage has no reset; the clear engine owns initialisation, so it never races a write.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= (clr_cnt == SENTINEL) ? DATA_WIDTH'(INIT0) : '0;
        end else if (wr_accept) begin
            mem[addr_write] <= data_in;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign mem_flat[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        strip_ram_rd_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_rd_port (
            .clk        (clk),
            .rst        (rst),
            .rd_accept  (rd_accept),
            .addr       (addr_read[p*ADDR_WIDTH +: ADDR_WIDTH]),
            .mem_flat   (mem_flat),
            .wr_accept  (wr_accept),
            .addr_write (addr_write),
            .data_in    (data_in),
            .data_out   (data_out[p*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_strip_ram_mp.sv
// tb/tb_strip_ram_mp.sv - self-checking bench for strip_ram_mp against a behavioural model
module tb_strip_ram_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_req = 1'b0;
    logic        busy;
    logic        write_en = 1'b0;
    logic [3:0]  addr_write = '0;
    logic [7:0]  data_in = '0;
    logic        wr_err;
    logic        read_en = 1'b0;
    logic [11:0] addr_read = '0;
    logic [23:0] data_out;
    logic        rd_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  m_mem [14];
    bit          m_busy;
    int          m_left;
    logic [23:0] exp_dout;
    bit          exp_rv, exp_err;

    always #5 clk = ~clk;

    strip_ram_mp dut (
        .clk        (clk),
        .rst        (rst),
        .init_req   (init_req),
        .busy       (busy),
        .write_en   (write_en),
        .addr_write (addr_write),
        .data_in    (data_in),
        .wr_err     (wr_err),
        .read_en    (read_en),
        .addr_read  (addr_read),
        .data_out   (data_out),
        .rd_valid   (rd_valid)
    );

    task automatic model_reset();
        m_busy   = 1'b1;
        m_left   = 14;
        exp_dout = '0;
        exp_rv   = 1'b0;
        exp_err  = 1'b0;
    endtask

    task automatic model_step(input bit we, input int wa, input logic [7:0] wd,
                              input bit re, input logic [11:0] ra, input bit ir);
        bit we_ok;
        int a;
        we_ok   = !m_busy && we && wa > 0 && wa < 14;
        exp_err = we && !we_ok;
        exp_rv  = !m_busy && re;
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                foreach (m_mem[k]) m_mem[k] = 8'd0;
                m_mem[0] = 8'd128;
            end
        end else begin
            if (re) begin
                for (int i = 0; i < 3; i++) begin
                    a = int'(ra[i*4 +: 4]);
                    if (a >= 14) exp_dout[i*8 +: 8] = 8'd0;
`ifdef WRITE_BYPASS_EN
                    else if (we_ok && a == wa) exp_dout[i*8 +: 8] = wd;
`endif
                    else exp_dout[i*8 +: 8] = m_mem[a];
                end
            end
            if (we_ok) m_mem[wa] = wd;
            if (ir) begin
                m_busy = 1'b1;
                m_left = 14;
            end
        end
    endtask

    // Drives one cycle of inputs, advances the model, and samples 1 time unit after the edge.
    task automatic step(input bit we, input int wa, input logic [7:0] wd,
                        input bit re, input logic [11:0] ra, input bit ir);
        write_en   = we;
        addr_write = 4'(wa);
        data_in    = wd;
        read_en    = re;
        addr_read  = ra;
        init_req   = ir;
        model_step(we, wa, wd, re, ra, ir);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 8'd0, 0, 12'd0, 0);
    endtask

    task automatic count_clear(input string name);
        int edges = 0;
        while (busy === 1'b1 && edges < 40) begin
            idle();
            edges++;
        end
        n_checks++;
        if (edges !== 14) begin
            n_fail++;
            $display("FAIL %s: clear took %0d edges, expected 14", name, edges);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || rd_valid !== 1'b0 || wr_err !== 1'b0 || data_out !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b rv=%b err=%b dout=%h, expected 1 0 0 000000",
                     busy, rd_valid, wr_err, data_out);
        end
        rst = 1'b0;
        model_reset();
        count_clear("reset_clear_len");
    endtask

    task automatic test_clear_seq();
        step(0, 0, 8'd0, 1, {4'd13, 4'd1, 4'd0}, 0);
        n_checks++;
        if (data_out !== 24'h000080 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_contents: dout=%h rv=%b, expected 000080 1", data_out, rd_valid);
        end
        idle();
        n_checks++;
        if (rd_valid !== 1'b0 || data_out !== 24'h000080) begin
            n_fail++;
            $display("FAIL rd_valid_pulse: rv=%b dout=%h, expected 0 000080", rd_valid, data_out);
        end
    endtask

    task automatic test_write_read();
        step(1, 3, 8'h5A, 0, 12'd0, 0);
        step(1, 12, 8'hC3, 0, 12'd0, 0);
        n_checks++;
        if (wr_err !== 1'b0 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_ok: err=%b rv=%b, expected 0 0", wr_err, rd_valid);
        end
        step(0, 0, 8'd0, 1, {4'd3, 4'd12, 4'd3}, 0);
        n_checks++;
        if (data_out !== 24'h5AC35A || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL write_read: dout=%h rv=%b, expected 5ac35a 1", data_out, rd_valid);
        end
    endtask

    task automatic test_protect();
        int bad [3] = '{0, 14, 15};
        foreach (bad[k]) begin
            step(1, bad[k], 8'hFF, 0, 12'd0, 0);
            n_checks++;
            if (wr_err !== 1'b1) begin
                n_fail++;
                $display("FAIL wr_err_addr%0d: err=%b, expected 1", bad[k], wr_err);
            end
        end
        idle();
        n_checks++;
        if (wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_err_pulse: err=%b, expected 0", wr_err);
        end
        step(0, 0, 8'd0, 1, {4'd15, 4'd14, 4'd0}, 0);
        n_checks++;
        if (data_out !== 24'h000080) begin
            n_fail++;
            $display("FAIL sentinel_and_oob: dout=%h, expected 000080", data_out);
        end
        step(0, 0, 8'd0, 1, {4'd13, 4'd12, 4'd3}, 0);
        n_checks++;
        if (data_out !== 24'h00C35A) begin
            n_fail++;
            $display("FAIL entries_unchanged: dout=%h, expected 00c35a", data_out);
        end
    endtask

    task automatic test_simultaneous();
        logic [23:0] want;
`ifdef WRITE_BYPASS_EN
        want = 24'h777777;
`else
        want = 24'h000000;
`endif
        step(1, 5, 8'h77, 1, {4'd5, 4'd5, 4'd5}, 0);
        n_checks++;
        if (data_out !== want || data_out !== exp_dout) begin
            n_fail++;
            $display("FAIL same_cycle_rw: dout=%h, expected %h", data_out, want);
        end
        step(0, 0, 8'd0, 1, {4'd5, 4'd0, 4'd5}, 0);
        n_checks++;
        if (data_out !== 24'h778077) begin
            n_fail++;
            $display("FAIL write_landed: dout=%h, expected 778077", data_out);
        end
    endtask

    task automatic test_busy();
        int edges;
        logic [23:0] held;
        step(1, 4, 8'h44, 0, 12'd0, 0);
        step(0, 0, 8'd0, 1, {4'd4, 4'd4, 4'd4}, 1);
        held = data_out;
        n_checks++;
        if (busy !== 1'b1 || held !== 24'h444444) begin
            n_fail++;
            $display("FAIL init_accept: busy=%b dout=%h, expected 1 444444", busy, held);
        end
        step(1, 4, 8'h99, 1, {4'd0, 4'd0, 4'd0}, 0);
        n_checks++;
        if (wr_err !== 1'b1 || rd_valid !== 1'b0 || data_out !== held) begin
            n_fail++;
            $display("FAIL busy_reject: err=%b rv=%b dout=%h, expected 1 0 %h",
                     wr_err, rd_valid, data_out, held);
        end
        edges = 1;
        while (busy === 1'b1 && edges < 40) begin
            idle();
            edges++;
        end
        n_checks++;
        if (edges !== 14) begin
            n_fail++;
            $display("FAIL init_clear_len: %0d edges, expected 14", edges);
        end
        step(0, 0, 8'd0, 1, {4'd0, 4'd3, 4'd4}, 0);
        n_checks++;
        if (data_out !== 24'h800000 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL after_clear: dout=%h rv=%b, expected 800000 1", data_out, rd_valid);
        end
    endtask

    task automatic test_reset_mid_clear();
        step(0, 0, 8'd0, 0, 12'd0, 1);
        repeat (5) idle();
        rst = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 24'd0 || busy !== 1'b1 || rd_valid !== 1'b0 || wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: dout=%h busy=%b rv=%b err=%b, expected 000000 1 0 0",
                     data_out, busy, rd_valid, wr_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        count_clear("restart_clear_len");
        step(0, 0, 8'd0, 1, {4'd0, 4'd13, 4'd0}, 0);
        n_checks++;
        if (data_out !== 24'h800080) begin
            n_fail++;
            $display("FAIL restart_contents: dout=%h, expected 800080", data_out);
        end
    endtask

    task automatic test_random();
        logic [11:0] ra;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) ra[i*4 +: 4] = 4'($urandom_range(0, 15));
            step($urandom_range(0, 1), $urandom_range(0, 15), 8'($urandom),
                 $urandom_range(0, 1), ra, $urandom_range(0, 49) == 0);
            n_checks++;
            if (data_out !== exp_dout || rd_valid !== exp_rv || wr_err !== exp_err
                || busy !== m_busy) begin
                n_fail++;
                $display("FAIL random_c%0d: dout=%h rv=%b err=%b busy=%b, expected %h %b %b %b",
                         c, data_out, rd_valid, wr_err, busy, exp_dout, exp_rv, exp_err, m_busy);
            end
        end
    endtask

    initial begin
        model_reset();
        foreach (m_mem[k]) m_mem[k] = 8'd0;
        test_reset();
        test_clear_seq();
        test_write_read();
        test_protect();
        test_simultaneous();
        test_busy();
        test_reset_mid_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
